fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit CPU.
- Owns the 12-bit program counter and drives it to the instruction memory as PCAdd_pc.
- Takes back the combinational M_instruction and registers it with its PC into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, a HALT opcode, and a saturating fetch counter.

Parameters:
RESET_PC, 12'h000, PC value loaded on reset.
HALT_OPCODE, 4'hF, value of instruction[15:12] that stops fetching.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
redirect_valid  input  1  branch/jump taken, asserted by EX.
redirect_pc  input  12  target PC, valid when redirect_valid=1.
PCAdd_pc  output  12  current PC, driven to instruction memory; equals the PC register, no logic in the path.
M_instruction  input  16  instruction word read combinationally at PCAdd_pc.
if_instruction  output  16  IF/ID registered instruction.
if_pc  output  12  IF/ID registered PC of if_instruction.
if_valid  output  1  IF/ID contents are a real instruction; 0 means bubble.
halted  output  1  1 while in HALT state.
fetch_count  output  16  number of instructions written to IF/ID with valid=1; saturates at 16'hFFFF.

Behaviour:
- Reset: asynchronous on rst_n=0, taking effect immediately regardless of clk.
  - Values: PC=RESET_PC, if_instruction=16'h0000, if_pc=12'h000, if_valid=0, halted=0, state=RUN, fetch_count=0.
  - Reset asserted mid-operation discards everything in flight.
- States: RUN, HALT. The halted output equals (state==HALT).
- Per-edge priority: redirect_valid > stall > normal fetch / HALT detection.
- Redirect (any state, stall ignored):
  - PC<=redirect_pc; if_valid<=0 (flush); state<=RUN.
  - if_instruction and if_pc may hold stale values; consumers qualify with if_valid.
  - A HALT opcode present on M_instruction in that cycle is discarded.
- Stall (no redirect), any state: PC, if_instruction, if_pc, if_valid, state and fetch_count all hold.
- RUN, no stall, no redirect:
  - if_instruction<=M_instruction; if_pc<=PC; if_valid<=1; fetch_count increments, saturating.
  - If M_instruction[15:12]==HALT_OPCODE: PC holds and state<=HALT. The HALT instruction itself is delivered valid.
  - Otherwise PC<=PC+1, modulo 4096, so 12'hFFF wraps to 12'h000.
- HALT, no stall, no redirect: PC holds; if_valid<=0; fetch_count holds. Only a redirect or reset leaves HALT.
- Latency: an instruction at PC p, fetched at edge n, appears on if_instruction/if_pc with if_valid=1 after edge n. Throughput is one instruction per cycle when unstalled.
- First fetch after reset uses RESET_PC; if_valid first rises after the first unstalled edge.
- No X propagation: all registers reset, and no output depends on M_instruction combinationally.

Test Plan:
- Sequential fetch: reset, then run 4 cycles over mem {0:16'h1438, 1:16'h282F, 2:16'h1121, 3:16'h1242} -> if_pc 0,1,2,3 with matching if_instruction; if_valid=1 from the first edge; fetch_count=4; PCAdd_pc=4.
- Stall: stall=1 for 2 cycles while if_pc=1 -> if_pc/if_instruction/PCAdd_pc/fetch_count unchanged for 2 cycles, then resume at if_pc=2 with no duplicate or skipped instruction.
- Redirect with stall and flush: at PC=3, redirect_valid=1, redirect_pc=12'h100, stall=1 -> next edge if_valid=0 and PCAdd_pc=12'h100; following edge if_pc=12'h100, if_valid=1.
- HALT: place 16'hF000 at address 5 -> if_instruction=16'hF000 with if_valid=1, halted=1, PCAdd_pc stays 5, then if_valid=0 indefinitely. A later redirect to 12'h000 -> halted=0 and fetch resumes at 0.
- Wrap and redirect-over-HALT: redirect to 12'hFFF (non-HALT word) -> next PC 12'h000. Redirect asserted in the same cycle M_instruction=16'hF123 -> halted stays 0 and PC=redirect_pc.
- Async reset mid-run: drop rst_n between clock edges with if_valid=1 and PC=12'h07A -> outputs immediately PCAdd_pc=RESET_PC, if_valid=0, halted=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 16-bit CPU. Owns the 12-bit PC, presents it
//   to instruction memory, and registers the returned word together with its
//   PC into the IF/ID pipeline register.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     stall            hazard hold: freezes PC, IF/ID, state and fetch_count
//     redirect_valid   branch/jump taken; loads redirect_pc and flushes IF/ID
//     redirect_pc      redirect target
//     PCAdd_pc         current PC to instruction memory (straight from the reg)
//     M_instruction    instruction word read combinationally at PCAdd_pc
//     if_instruction   IF/ID instruction
//     if_pc            IF/ID PC of if_instruction
//     if_valid         IF/ID holds a real instruction (0 = bubble)
//     halted           stage is in HALT
//     fetch_count      valid instructions delivered, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    output logic [11:0] PCAdd_pc,
    input  logic [15:0] M_instruction,
    output logic [15:0] if_instruction,
    output logic [11:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [11:0] pc;
        logic        valid;
    } ifid_t;

    state_t      state, state_nxt;
    logic [11:0] pc, pc_nxt;
    ifid_t       ifid, ifid_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        is_halt;

    assign is_halt = (M_instruction[15:12] == HALT_OPCODE);

    // State and datapath registers; reset is asynchronous so a mid-run
    // reset drops everything in flight without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
            ifid  <= '{instr: 16'h0000, pc: 12'h000, valid: 1'b0};
            cnt   <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ifid  <= ifid_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: redirect beats stall beats normal fetch / HALT handling.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ifid_nxt  = ifid;
        cnt_nxt   = cnt;
        if (redirect_valid) begin
            // Flush only the valid bit; data fields may go stale since
            // consumers qualify with if_valid. Any HALT word seen this
            // cycle is dropped along with the flushed fetch.
            pc_nxt         = redirect_pc;
            ifid_nxt.valid = 1'b0;
            state_nxt      = RUN;
        end else if (stall) begin
            // everything holds
        end else begin
            unique case (state)
                RUN: begin
                    ifid_nxt.instr = M_instruction;
                    ifid_nxt.pc    = pc;
                    ifid_nxt.valid = 1'b1;
                    if (cnt != 16'hFFFF) cnt_nxt = cnt + 16'd1;
                    if (is_halt) begin
                        // HALT itself is delivered valid; PC parks on it.
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc + 12'd1;  // wraps FFF -> 000
                    end
                end
                HALT: begin
                    ifid_nxt.valid = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign PCAdd_pc       = pc;
    assign if_instruction = ifid.instr;
    assign if_pc          = ifid.pc;
    assign if_valid       = ifid.valid;
    assign halted         = (state == HALT);
    assign fetch_count    = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] PCAdd_pc;
    logic [15:0] M_instruction;
    logic [15:0] if_instruction;
    logic [11:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:4095];
    logic        ovr;   // replace memory word with a HALT-opcode word

    int tests;
    int fails;

    fetch_stage #(.RESET_PC(12'h000), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .PCAdd_pc(PCAdd_pc), .M_instruction(M_instruction),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_valid(if_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign M_instruction = ovr ? 16'hF123 : mem[PCAdd_pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        rv;
        logic [11:0] rpc;
        logic        ovr;
        logic [11:0] e_pc;
        logic [11:0] e_ifpc;
        logic [15:0] e_instr;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic st, input logic rv, input logic [11:0] rpc,
                                input logic ov, input logic [11:0] epc, input logic [11:0] eifpc,
                                input logic [15:0] einstr, input logic ev, input logic eh,
                                input logic [15:0] ecnt);
        vec_t v;
        v.stall = st; v.rv = rv; v.rpc = rpc; v.ovr = ov;
        v.e_pc = epc; v.e_ifpc = eifpc; v.e_instr = einstr;
        v.e_valid = ev; v.e_halt = eh; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, ".PCAdd_pc"}, 32'(PCAdd_pc), 32'(v.e_pc));
        chk({tag, ".if_valid"}, 32'(if_valid), 32'(v.e_valid));
        chk({tag, ".halted"}, 32'(halted), 32'(v.e_halt));
        chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(v.e_cnt));
        if (v.e_valid) begin
            chk({tag, ".if_pc"}, 32'(if_pc), 32'(v.e_ifpc));
            chk({tag, ".if_instruction"}, 32'(if_instruction), 32'(v.e_instr));
        end
    endtask

    initial begin
        vec_t r;
        tests = 0;
        fails = 0;

        // Filler words use opcode 1 and carry their own address.
        for (int a = 0; a < 4096; a++) mem[a] = {4'h1, a[11:0]};
        mem[0] = 16'h1438; mem[1] = 16'h282F; mem[2] = 16'h1121; mem[3] = 16'h1242;
        mem[5] = 16'hF000;

        //            st rv rpc     ov  PC      if_pc   instr     v  h  cnt
        vecs[0]  = mk(0, 0, 12'h0,  0, 12'h001, 12'h000, 16'h1438, 1, 0, 16'd1);
        vecs[1]  = mk(0, 0, 12'h0,  0, 12'h002, 12'h001, 16'h282F, 1, 0, 16'd2);
        vecs[2]  = mk(0, 0, 12'h0,  0, 12'h003, 12'h002, 16'h1121, 1, 0, 16'd3);
        vecs[3]  = mk(0, 0, 12'h0,  0, 12'h004, 12'h003, 16'h1242, 1, 0, 16'd4);
        vecs[4]  = mk(0, 1, 12'h001,0, 12'h001, 12'h000, 16'h0000, 0, 0, 16'd4);
        vecs[5]  = mk(0, 0, 12'h0,  0, 12'h002, 12'h001, 16'h282F, 1, 0, 16'd5);
        vecs[6]  = mk(1, 0, 12'h0,  0, 12'h002, 12'h001, 16'h282F, 1, 0, 16'd5);
        vecs[7]  = mk(1, 0, 12'h0,  0, 12'h002, 12'h001, 16'h282F, 1, 0, 16'd5);
        vecs[8]  = mk(0, 0, 12'h0,  0, 12'h003, 12'h002, 16'h1121, 1, 0, 16'd6);
        vecs[9]  = mk(1, 1, 12'h100,0, 12'h100, 12'h000, 16'h0000, 0, 0, 16'd6);
        vecs[10] = mk(0, 0, 12'h0,  0, 12'h101, 12'h100, 16'h1100, 1, 0, 16'd7);
        vecs[11] = mk(0, 1, 12'h004,0, 12'h004, 12'h000, 16'h0000, 0, 0, 16'd7);
        vecs[12] = mk(0, 0, 12'h0,  0, 12'h005, 12'h004, 16'h1004, 1, 0, 16'd8);
        vecs[13] = mk(0, 0, 12'h0,  0, 12'h005, 12'h005, 16'hF000, 1, 1, 16'd9);
        vecs[14] = mk(0, 0, 12'h0,  0, 12'h005, 12'h000, 16'h0000, 0, 1, 16'd9);
        vecs[15] = mk(0, 0, 12'h0,  0, 12'h005, 12'h000, 16'h0000, 0, 1, 16'd9);
        vecs[16] = mk(1, 0, 12'h0,  0, 12'h005, 12'h000, 16'h0000, 0, 1, 16'd9);
        vecs[17] = mk(0, 1, 12'h000,0, 12'h000, 12'h000, 16'h0000, 0, 0, 16'd9);
        vecs[18] = mk(0, 0, 12'h0,  0, 12'h001, 12'h000, 16'h1438, 1, 0, 16'd10);
        vecs[19] = mk(0, 1, 12'hFFF,0, 12'hFFF, 12'h000, 16'h0000, 0, 0, 16'd10);
        vecs[20] = mk(0, 0, 12'h0,  0, 12'h000, 12'hFFF, 16'h1FFF, 1, 0, 16'd11);
        vecs[21] = mk(0, 0, 12'h0,  0, 12'h001, 12'h000, 16'h1438, 1, 0, 16'd12);
        vecs[22] = mk(0, 1, 12'h020,1, 12'h020, 12'h000, 16'h0000, 0, 0, 16'd12);
        vecs[23] = mk(0, 0, 12'h0,  0, 12'h021, 12'h020, 16'h1020, 1, 0, 16'd13);
        vecs[24] = mk(0, 1, 12'h079,0, 12'h079, 12'h000, 16'h0000, 0, 0, 16'd13);
        vecs[25] = mk(0, 0, 12'h0,  0, 12'h07A, 12'h079, 16'h1079, 1, 0, 16'd14);

        // Reset state, before any clock edge
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'h000; ovr = 1'b0;
        #1;
        chk("rst.PCAdd_pc", 32'(PCAdd_pc), 32'h000);
        chk("rst.if_valid", 32'(if_valid), 32'h0);
        chk("rst.halted", 32'(halted), 32'h0);
        chk("rst.fetch_count", 32'(fetch_count), 32'h0);
        chk("rst.if_pc", 32'(if_pc), 32'h000);
        chk("rst.if_instruction", 32'(if_instruction), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            ovr            = vecs[i].ovr;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i]);
        end
        stall = 1'b0; redirect_valid = 1'b0; ovr = 1'b0;

        // Async reset between edges with PC=07A and if_valid=1
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        r = mk(0, 0, 12'h0, 0, 12'h000, 12'h000, 16'h0000, 0, 0, 16'd0);
        chk_outs("async_rst", r);
        @(posedge clk);
        #1;
        chk_outs("rst_held", r);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        r = mk(0, 0, 12'h0, 0, 12'h001, 12'h000, 16'h1438, 1, 0, 16'd1);
        chk_outs("post_rst", r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
